// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle two's-complement add/subtract unit.
// Computes a + b + c_in (mode=0) or a - b - c_in (mode=1) over WIDTH bits,
// CHUNK bits per clock, least significant chunk first. It uses one CHUNK-bit
// adder and a one-bit running carry.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           operation request, accepted in IDLE or DONE
//   mode            0 = add, 1 = subtract (latched with start)
//   a, b            operands (latched with start)
//   c_in            carry-in (add) or borrow-in (sub) (latched with start)
//   busy            high while the operation is running
//   done            one-cycle pulse; result/c_out/ovf valid
//   result          sum or difference modulo 2^WIDTH
//   c_out           carry-out (add) or borrow-out (sub)
//   ovf             signed overflow
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] acc_next;

  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_chunk = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (decoded from registered state only)
  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    result = result_q;
    c_out  = c_out_q;
    ovf    = ovf_q;
  end

  // Chunk adder. Operands are shifted right each cycle, so the active chunk
  // always sits in the low CHUNK bits. Subtraction stores ~b and ~c_in at
  // latch time so the adder itself never needs to know the mode.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, op_q[CHUNK-1:0]}
              + (CHUNK+1)'(carry_q);
    // Carry into the chunk MSB, recovered from the MSB sum bit.
    msb_carry_in = a_q[CHUNK-1] ^ op_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
    // Result bits enter at the top and shift down; after N chunks the first
    // chunk has reached bit 0.
    acc_next = (acc_q >> CHUNK)
             | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d     = a;
      op_d    = mode ? ~b : b;
      carry_d = c_in ^ mode;
      mode_d  = mode;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d     = a_q >> CHUNK;
      op_d    = op_q >> CHUNK;
      carry_d = chunk_sum[CHUNK];
      acc_d   = acc_next;
      cnt_d   = last_chunk ? '0 : cnt_q + CW'(1);
      if (last_chunk) begin
        result_d = acc_next;
        // Final carry is an inverted borrow when subtracting.
        c_out_d  = chunk_sum[CHUNK] ^ mode_q;
        ovf_d    = msb_carry_in ^ chunk_sum[CHUNK];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and sweep bench for addsub_serial. Five instances share the input
// stimulus: WIDTH/CHUNK = 8/2, 4/1, 4/2, 4/4 and 16/4.
module tb_addsub_serial;

  localparam int WS [5] = '{8, 4, 4, 4, 16};
  localparam int NS [5] = '{4, 4, 2, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        c_in;
  logic [15:0] a;
  logic [15:0] b;

  logic [4:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  res0;
  logic [3:0]  res1, res2, res3;
  logic [15:0] res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .busy(busy_v[0]), .done(done_v[0]), .result(res0),
    .c_out(cout_v[0]), .ovf(ovf_v[0]));
  addsub_serial #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a[3:0]), .b(b[3:0]),
    .c_in(c_in), .busy(busy_v[1]), .done(done_v[1]), .result(res1),
    .c_out(cout_v[1]), .ovf(ovf_v[1]));
  addsub_serial #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a[3:0]), .b(b[3:0]),
    .c_in(c_in), .busy(busy_v[2]), .done(done_v[2]), .result(res2),
    .c_out(cout_v[2]), .ovf(ovf_v[2]));
  addsub_serial #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a[3:0]), .b(b[3:0]),
    .c_in(c_in), .busy(busy_v[3]), .done(done_v[3]), .result(res3),
    .c_out(cout_v[3]), .ovf(ovf_v[3]));
  addsub_serial #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .c_in(c_in), .busy(busy_v[4]), .done(done_v[4]), .result(res4),
    .c_out(cout_v[4]), .ovf(ovf_v[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: returns {ovf, c_out, result[15:0]} for width w.
  function automatic logic [17:0] model(input int w, input logic m,
                                        input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] xm, ym, full;
    logic [15:0] mask, r;
    logic        co, ov, sa, sb, sr;
    mask = 16'((17'd1 << w) - 17'd1);
    xm   = {1'b0, x & mask};
    ym   = {1'b0, y & mask};
    if (!m) begin
      full = xm + ym + 17'(ci);
      co   = full[w];
    end else begin
      full = xm - ym - 17'(ci);
      co   = (xm < (ym + 17'(ci)));
    end
    r  = full[15:0] & mask;
    sa = xm[w-1];
    sb = ym[w-1];
    sr = r[w-1];
    ov = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, co, r};
  endfunction

  function automatic logic [17:0] dut_out(input int i);
    logic [15:0] r;
    case (i)
      0:       r = {8'h00, res0};
      1:       r = {12'h000, res1};
      2:       r = {12'h000, res2};
      3:       r = {12'h000, res3};
      default: r = res4;
    endcase
    return {ovf_v[i], cout_v[i], r};
  endfunction

  // One operation on all instances: checks value, latency (N+1 edges from the
  // start edge), a single done pulse and N busy cycles. Operands are scrambled
  // right after the latch edge.
  task automatic run_op(input string tag, input logic m, input logic [15:0] x,
                        input logic [15:0] y, input logic ci, input bit verbose,
                        output logic [17:0] got8);
    int          lat [5];
    int          nd  [5];
    int          nb  [5];
    logic [17:0] got [5];
    for (int i = 0; i < 5; i++) begin
      lat[i] = 0; nd[i] = 0; nb[i] = 0; got[i] = '0;
    end
    @(negedge clk);
    mode = m; a = x; b = y; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); c_in = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (done_v[i]) begin
          nd[i]++;
          if (nd[i] == 1) begin
            lat[i] = k;
            got[i] = dut_out(i);
          end
        end
        if (busy_v[i]) nb[i]++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_d%0d_val", tag, i), 32'(got[i]), 32'(model(WS[i], m, x, y, ci)));
      chk($sformatf("%s_d%0d_lat", tag, i), 32'(lat[i]), 32'(NS[i] + 1));
      chk($sformatf("%s_d%0d_ndone", tag, i), 32'(nd[i]), 32'd1);
      chk($sformatf("%s_d%0d_nbusy", tag, i), 32'(nb[i]), 32'(NS[i]));
    end
    got8 = got[0];
    if (verbose)
      $display("op %s mode=%0d a=0x%04h b=0x%04h cin=%0d -> w8 ovf=%0d cout=%0d res=0x%02h lat=%0d",
               tag, m, x, y, ci, got[0][17], got[0][16], got[0][7:0], lat[0]);
  endtask

  typedef struct {
    string       tag;
    logic        m;
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic [17:0] exp8;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [17:0] got8;
    int          k, j, nd;

    vecs[0] = '{"sub_05_03",   1'b1, 16'h05, 16'h03, 1'b0, {1'b0, 1'b0, 16'h02}};
    vecs[1] = '{"sub_00_01",   1'b1, 16'h00, 16'h01, 1'b0, {1'b0, 1'b1, 16'hFF}};
    vecs[2] = '{"sub_10_0F_b", 1'b1, 16'h10, 16'h0F, 1'b1, {1'b0, 1'b0, 16'h00}};
    vecs[3] = '{"sub_80_01",   1'b1, 16'h80, 16'h01, 1'b0, {1'b1, 1'b0, 16'h7F}};
    vecs[4] = '{"add_7F_01",   1'b0, 16'h7F, 16'h01, 1'b0, {1'b1, 1'b0, 16'h80}};
    vecs[5] = '{"add_FF_01_c", 1'b0, 16'hFF, 16'h01, 1'b1, {1'b0, 1'b1, 16'h01}};

    rst = 1'b1; start = 1'b0; mode = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_w8", {27'd0, busy_v[0], done_v[0], ovf_v[0], cout_v[0], res0}, 32'd0);
    chk("reset_w16", {13'd0, busy_v[4], done_v[4], ovf_v[4], cout_v[4], res4}, 32'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed 8-bit expectations
    foreach (vecs[i]) begin
      run_op(vecs[i].tag, vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].ci, 1'b1, got8);
      chk({vecs[i].tag, "_hand"}, 32'(got8), 32'(vecs[i].exp8));
    end

    // start pulsed during RUN is ignored
    @(negedge clk);
    mode = 1'b0; a = 16'h21; b = 16'h13; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1;
    @(negedge clk);
    k = 2; mode = 1'b1; a = 16'hFF; b = 16'hAA; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 3;
    while (!done_v[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ign_lat", 32'(k), 32'd5);
    chk("ign_val", {14'd0, ovf_v[0], cout_v[0], 8'd0, res0}, {14'd0, 1'b0, 1'b0, 16'h0034});
    @(negedge clk);
    chk("ign_idle", {30'd0, busy_v[0], done_v[0]}, 32'd0);
    $display("op ignore_start add 0x21+0x13 -> res=0x%02h lat=%0d", res0, k);
    repeat (8) @(negedge clk);

    // Back-to-back: start held in DONE relaunches immediately
    @(negedge clk);
    mode = 1'b1; a = 16'h05; b = 16'h03; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1;
    while (!done_v[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat1", 32'(k), 32'd5);
    chk("b2b_val1", {24'd0, res0}, 32'h02);
    mode = 1'b0; a = 16'h7F; b = 16'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; j = 1;
    chk("b2b_busy", {31'd0, busy_v[0]}, 32'd1);
    while (!done_v[0] && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("b2b_gap", 32'(j), 32'd5);
    chk("b2b_val2", {22'd0, ovf_v[0], cout_v[0], res0}, {22'd0, 1'b1, 1'b0, 8'h80});
    $display("op back_to_back sub 0x05-0x03 then add 0x7F+0x01 -> res=0x%02h gap=%0d", res0, j);
    repeat (8) @(negedge clk);

    // Reset in the middle of RUN
    @(negedge clk);
    mode = 1'b0; a = 16'h55; b = 16'h22; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", {27'd0, busy_v[0], done_v[0], ovf_v[0], cout_v[0], res0}, 32'd0);
    nd = 0;
    repeat (8) begin
      if (done_v[0]) nd++;
      @(negedge clk);
    end
    chk("rst_nodone", 32'(nd), 32'd0);
    $display("op reset_mid_run -> outputs cleared, done pulses=%0d", nd);
    run_op("rst_after", 1'b0, 16'h12, 16'h34, 1'b0, 1'b1, got8);
    chk("rst_after_hand", 32'(got8), {14'd0, 18'h00046});

    // Exhaustive 4-bit sweep (upper bits random for the wider instances)
    for (int m = 0; m < 2; m++)
      for (int ci = 0; ci < 2; ci++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            run_op("sweep", 1'(m), {12'($urandom), 4'(x)}, {12'($urandom), 4'(y)},
                   1'(ci), 1'b0, got8);
    $display("op exhaustive_4bit sweep complete, errors so far=%0d", errors);

    for (int r = 0; r < 150; r++)
      run_op("rand", 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, got8);
    $display("op random_16bit sweep complete, errors so far=%0d", errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
